przesuniecie_lewo_seq: RTL and testbench
========================================

// Module: przesuniecie_lewo_seq
// PURPOSE
//  Sequential arithmetic LEFT shift of i_arg_A by n = ~i_arg_B bits; inverse direction of the
//  combinational right-shift unit, same operand encoding and same error/overflow flag semantics.
//  One bit shifted per clock under a start/busy/done handshake; sits in the synchronous arithmetic
//  unit beside the other operation blocks, result selected by the unit's output mux.
// PARAMETERS
//  BITS   32   operand/result width; shift amount n = ~i_arg_B read as signed BITS-bit value
// PORTS
//  i_clk       in   1     clock, all state updates on rising edge
//  i_rst_n     in   1     synchronous reset, active-low
//  i_start     in   1     request; sampled only in IDLE
//  i_arg_A     in   BITS  operand to shift (signed)
//  i_arg_B     in   BITS  inverted shift amount; n = ~i_arg_B (signed)
//  o_result    out  BITS  shifted result, valid from o_done cycle until next accepted start
//  o_error     out  1     n < 0
//  o_overflow  out  1     signed overflow of the left shift
//  o_busy      out  1     high from cycle after accepted start until o_done cycle (inclusive)
//  o_done      out  1     one-cycle pulse: result/flags valid
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge): state IDLE, o_result='0, o_error=0, o_overflow=0, o_busy=0,
//   o_done=0, shift counter=0; reset mid-operation aborts with no o_done pulse.
//  States: IDLE, SHIFT, DONE (enum in package).
//  IDLE & i_start at edge T: latch A into shift reg, sign0=A[BITS-1], clear flags, classify n:
//   n<0          -> o_result='0, o_error=1, o_overflow=0, go DONE
//   n==0         -> o_result=A, flags 0, go DONE
//   n>=BITS      -> o_result='0, o_error=0, o_overflow=(A!=0), go DONE
//   1<=n<=BITS-1 -> cnt=n[$clog2(BITS)-1:0], go SHIFT
//  SHIFT, each edge: reg <= {reg[BITS-2:0],1'b0}; if reg[BITS-1]!=sign0 or reg[BITS-2]!=sign0
//   set sticky overflow; cnt--; when cnt==1 at edge, go DONE.
//  DONE: o_done=1 for exactly one cycle, o_result=reg, flags final; next edge -> IDLE.
//  Latency: edge T start; o_done high during cycle T+1 (direct cases) or T+n+1 (SHIFT path).
//  i_start while SHIFT/DONE ignored (not queued); i_start in DONE cycle also ignored.
//  Back-to-back: start accepted in the IDLE cycle right after DONE.
//  Inputs sampled only at accept edge; later changes of i_arg_A/i_arg_B have no effect.
//  o_result/flags hold last values in IDLE; cleared only on next accepted start or reset.
//  Overflow rule: set iff any shifted-out bit or final sign bit differs from sign0.
//  n compare is signed BITS-bit; n==BITS counts as >=BITS (all bits shifted out).
// STRUCTURE
//  Package arith_pkg: typedef enum logic [1:0] {IDLE,SHIFT,DONE} shift_state_t;
//   default BITS constant; helper function classify_shift(n) returning {neg,zero,big}.
//  Counter width $clog2(BITS) derived locally from BITS.
//  Single FSM + datapath in this module; no sub-module required.
// TESTING (BITS=32)
//  A=0x0000_0003, B=0xFFFF_FFFD (n=2) -> o_result=0x0000_000C, flags 0, o_done at T+3
//  A=0x4000_0000, B=0xFFFF_FFFE (n=1) -> o_result=0x8000_0000, o_overflow=1, o_error=0
//  A=0x1234_5678, B=0xFFFF_FFFF (n=0) -> o_result=0x1234_5678, flags 0, o_done at T+1
//  B=0x0000_0000 (n=-1) -> o_error=1, o_overflow=0, o_result=0; B=0xFFFF_FFDF (n=32): A=5 ->
//   o_overflow=1, result 0; A=0 -> o_overflow=0
//  n=20 start, second i_start at T+5 ignored; i_rst_n=0 at T+10 -> all outputs 0, no o_done
//  Back-to-back: two n=3 ops, second start in IDLE after DONE -> two o_done pulses 5 cycles apart

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared state type, default width and shift-amount classifier for the arithmetic unit
package arith_pkg;
  localparam int DEF_BITS = 32;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;
  function automatic logic [2:0] classify_shift(input longint n, input int bits);
    return {n < 0, n == 0, n >= longint'(bits)};
  endfunction
endpackage

// File: rtl/przesuniecie_lewo_seq.sv
// przesuniecie_lewo_seq: bit-serial arithmetic left shift by n = ~i_arg_B with error/overflow flags
module przesuniecie_lewo_seq
  import arith_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  output logic [BITS-1:0] o_result,
  output logic            o_error,
  output logic            o_overflow,
  output logic            o_busy,
  output logic            o_done
);
  localparam int CW = $clog2(BITS);
  shift_state_t state, state_nx;
  logic [BITS-1:0] sreg;
  logic [CW-1:0] cnt;
  logic sign0, err, ovf, accept;
  logic signed [BITS-1:0] n;
  logic [2:0] cls;
  assign n = ~i_arg_B;
  assign cls = classify_shift(longint'(n), BITS);
  assign accept = state == IDLE && i_start;
  assign o_result = sreg;
  assign o_error = err;
  assign o_overflow = ovf;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  always_comb begin
    state_nx = state == IDLE  ? (i_start ? (|cls ? DONE : SHIFT) : IDLE) :
               state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      sign0 <= 1'b0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sign0 <= i_arg_A[BITS-1];
        err   <= cls[2];
        ovf   <= cls[0] && |i_arg_A;
        sreg  <= (cls[2] || cls[0]) ? '0 : i_arg_A;
        cnt   <= n[CW-1:0];
      end else if (state == SHIFT) begin
        // the outgoing MSB and the incoming sign bit must both match the original sign
        sreg <= {sreg[BITS-2:0], 1'b0};
        ovf  <= ovf || sreg[BITS-1] != sign0 || sreg[BITS-2] != sign0;
        cnt  <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_przesuniecie_lewo_seq.sv
// tb_przesuniecie_lewo_seq: directed and random checks of the serial left shifter against an arithmetic model
module tb_przesuniecie_lewo_seq;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0;
  logic [31:0] i_arg_A = '0, i_arg_B = '0, o_result;
  logic o_error, o_overflow, o_busy, o_done;
  int total = 0, bad = 0;
  always #5 i_clk = ~i_clk;
  przesuniecie_lewo_seq #(.BITS(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_arg_A(i_arg_A), .i_arg_B(i_arg_B),
    .o_result(o_result), .o_error(o_error), .o_overflow(o_overflow), .o_busy(o_busy), .o_done(o_done)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // reference: value semantics of A * 2**n in 32-bit two's complement
  task automatic model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                       output logic err, output logic ovf, output int lat);
    int n;
    longint p;
    n = int'(~b);
    lat = 0;
    err = 0;
    ovf = 0;
    res = '0;
    if (n < 0) err = 1;
    else if (n >= 32) ovf = a != 0;
    else begin
      res = a << n;
      p = longint'($signed(a)) * (longint'(1) << n);
      ovf = p != longint'($signed(res));
      lat = n;
    end
  endtask
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] er;
    logic ee, eo;
    int lat, k;
    model(a, b, er, ee, eo, lat);
    @(negedge i_clk);
    i_arg_A = a;
    i_arg_B = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    if (!hold) i_start = 1'b0;
    i_arg_A = $urandom;
    i_arg_B = $urandom;
    check("busy_after_start", 32'(o_busy), 32'd1);
    k = 0;
    while (!o_done && k < 40) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    check("latency", k, lat);
    check("result", o_result, er);
    check("error", 32'(o_error), 32'(ee));
    check("overflow", 32'(o_overflow), 32'(eo));
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    check("done_pulse", 32'(o_done), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("result_hold", o_result, er);
    check("overflow_hold", 32'(o_overflow), 32'(eo));
  endtask
  initial begin
    int q[$];
    int n;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_result", o_result, 32'd0);
    check("rst_flags", {28'd0, o_error, o_overflow, o_busy, o_done}, 32'd0);
    i_rst_n = 1'b1;
    run_op(32'h0000_0003, 32'hFFFF_FFFD, 0);
    run_op(32'h4000_0000, 32'hFFFF_FFFE, 0);
    run_op(32'h1234_5678, 32'hFFFF_FFFF, 0);
    run_op(32'h1234_5678, 32'h0000_0000, 0);
    run_op(32'h0000_0005, 32'hFFFF_FFDF, 0);
    run_op(32'h0000_0000, 32'hFFFF_FFDF, 0);
    run_op(32'hFFFF_FFFF, ~32'd31, 0);
    run_op(32'hC000_0001, ~32'd1, 0);
    run_op(32'h0000_00A5, ~32'd5, 1);
    for (int i = 0; i < 24; i++) begin
      n = int'($urandom_range(0, 38)) - 3;
      run_op(i[0] ? $urandom : ($urandom >> $urandom_range(0, 31)), ~n, 0);
    end
    @(negedge i_clk);
    i_arg_A = 32'h0000_1234;
    i_arg_B = ~32'd20;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    i_start = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    i_start = 1'b0;
    check("mid_busy", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    check("abort_result", o_result, 32'd0);
    check("abort_flags", {28'd0, o_error, o_overflow, o_busy, o_done}, 32'd0);
    n = 0;
    repeat (25) begin
      @(posedge i_clk);
      #1;
      n += int'(o_done) + int'(o_busy);
    end
    check("abort_no_done", n, 0);
    @(negedge i_clk);
    i_arg_A = 32'd3;
    i_arg_B = ~32'd3;
    i_start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge i_clk);
      #1;
      if (o_done) q.push_back(i);
    end
    i_start = 1'b0;
    check("b2b_count", q.size(), 3);
    if (q.size() >= 2) begin
      check("b2b_first", q[0], 4);
      check("b2b_gap", q[1] - q[0], 5);
    end
    check("b2b_result", o_result, 32'd24);
    repeat (3) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
